// File: rtl/entrada_juego.sv
// Input conditioning and round timing ahead of the end-of-round FSM:
// button sync/debounce, press and double-press pulses, and a sticky round timer.
module entrada_juego #(
  parameter int DEB_CYCLES    = 4,
  parameter int WINDOW_CYCLES = 20,
  parameter int ROUND_CYCLES  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_raw,
  input  logic        start,
  output logic        finalizar,
  output logic        dos_p,
  output logic        pulsacion,
  output logic [15:0] cuenta_ronda
);

  localparam int DW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int WW_RAW = $clog2(WINDOW_CYCLES + 1) + 1;
  localparam int WW     = (WW_RAW > 5) ? WW_RAW : 5;

  typedef enum logic {DP_IDLE, DP_WAIT} dp_state_t;
  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} t_state_t;

  logic          sync1_q;
  logic          btn_sync_q;
  logic          btn_stable_q, btn_stable_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          puls_q, puls_d;
  dp_state_t     dp_state_q, dp_state_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic          dos_q, dos_d;
  t_state_t      t_state_q, t_state_d;
  logic [15:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      btn_sync_q   <= 1'b0;
      btn_stable_q <= 1'b0;
      deb_cnt_q    <= '0;
      puls_q       <= 1'b0;
      dp_state_q   <= DP_IDLE;
      win_cnt_q    <= '0;
      dos_q        <= 1'b0;
      t_state_q    <= T_IDLE;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw;
      btn_sync_q   <= sync1_q;
      btn_stable_q <= btn_stable_d;
      deb_cnt_q    <= deb_cnt_d;
      puls_q       <= puls_d;
      dp_state_q   <= dp_state_d;
      win_cnt_q    <= win_cnt_d;
      dos_q        <= dos_d;
      t_state_q    <= t_state_d;
      cnt_q        <= cnt_d;
    end
  end

  // Debounce: the stable value flips only after DEB_CYCLES consecutive disagreements.
  always_comb begin
    btn_stable_d = btn_stable_q;
    deb_cnt_d    = '0;
    if (btn_sync_q != btn_stable_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
        btn_stable_d = ~btn_stable_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    puls_d = btn_stable_d & ~btn_stable_q;
  end

  always_comb begin
    dp_state_d = dp_state_q;
    win_cnt_d  = win_cnt_q;
    dos_d      = 1'b0;
    case (dp_state_q)
      DP_IDLE: begin
        if (puls_q) begin
          dp_state_d = DP_WAIT;
          win_cnt_d  = WW'(1);
        end
      end
      DP_WAIT: begin
        if (puls_q && (win_cnt_q <= WW'(WINDOW_CYCLES))) begin
          dos_d      = 1'b1;
          dp_state_d = DP_IDLE;
          win_cnt_d  = '0;
        end else if (win_cnt_q == WW'(WINDOW_CYCLES)) begin
          dp_state_d = DP_IDLE;
          win_cnt_d  = '0;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
        end
      end
      default: begin
        dp_state_d = DP_IDLE;
        win_cnt_d  = '0;
      end
    endcase
  end

  // Round timer: T_DONE is terminal until reset, so finalizar stays asserted.
  always_comb begin
    t_state_d = t_state_q;
    cnt_d     = cnt_q;
    case (t_state_q)
      T_IDLE: begin
        cnt_d = '0;
        if (start) begin
          t_state_d = T_RUN;
        end
      end
      T_RUN: begin
        if (cnt_q == 16'(ROUND_CYCLES - 1)) begin
          t_state_d = T_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      T_DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        t_state_d = T_IDLE;
        cnt_d     = '0;
      end
    endcase
  end

  assign finalizar    = (t_state_q == T_DONE);
  assign dos_p        = dos_q;
  assign pulsacion    = puls_q;
  assign cuenta_ronda = cnt_q;

endmodule

// File: tb/tb_entrada_juego.sv
// Directed bench for entrada_juego: reset, debounce, double press windows,
// round timer and reset in the middle of activity.
module tb_entrada_juego;

  logic        clk;
  logic        rst;
  logic        btn_raw;
  logic        start;
  logic        finalizar;
  logic        dos_p;
  logic        pulsacion;
  logic [15:0] cuenta_ronda;

  int n_cmp = 0;
  int n_err = 0;

  int n_puls, n_dos, dos_at, first_puls, first_fin;

  entrada_juego #(
    .DEB_CYCLES   (4),
    .WINDOW_CYCLES(20),
    .ROUND_CYCLES (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .start       (start),
    .finalizar   (finalizar),
    .dos_p       (dos_p),
    .pulsacion   (pulsacion),
    .cuenta_ronda(cuenta_ronda)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic bit in_press(input int c, input int r);
    return (r >= 0) && (c >= r) && (c < r + 4);
  endfunction

  // A rise at iteration r holds btn_raw high for 4 cycles; its pulse lands at index r+6.
  task automatic run_seq(input int n, input int ra, input int rb, input int rc);
    n_puls = 0; n_dos = 0; dos_at = -1; first_puls = -1;
    for (int c = 0; c < n; c++) begin
      btn_raw = in_press(c, ra) || in_press(c, rb) || in_press(c, rc);
      step();
      if (pulsacion) begin
        n_puls++;
        if (first_puls < 0) first_puls = c + 1;
      end
      if (dos_p) begin
        n_dos++;
        if (dos_at < 0) dos_at = c + 1;
      end
    end
    btn_raw = 1'b0;
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; btn_raw = 1'b0; start = 1'b0;

    // Asynchronous reset before any clock edge.
    #3 rst = 1'b1;
    #1;
    check("rst_fin",   32'(finalizar), 0);
    check("rst_dos",   32'(dos_p), 0);
    check("rst_puls",  32'(pulsacion), 0);
    check("rst_cuenta", 32'(cuenta_ronda), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      check("idle_outs", {13'd0, finalizar, dos_p, pulsacion, cuenta_ronda}, 0);
    end

    // Glitches 1,0,1,0 then a held 1: stable level first sampled at index 5.
    n_puls = 0; n_dos = 0; first_puls = -1;
    for (int c = 0; c < 30; c++) begin
      btn_raw = (c < 4) ? ((c % 2) == 0) : 1'b1;
      step();
      if (pulsacion) begin
        n_puls++;
        if (first_puls < 0) first_puls = c + 1;
      end
      if (dos_p) n_dos++;
    end
    check("deb_npuls", n_puls, 1);
    check("deb_at",    first_puls, 10);
    btn_raw = 1'b0;
    run_seq(40, -1, -1, -1);
    check("deb_fall_npuls", n_puls, 0);
    check("deb_fall_dos",   n_dos, 0);

    run_seq(50, 0, 10, -1);
    check("dp10_npuls", n_puls, 2);
    check("dp10_ndos",  n_dos, 1);
    check("dp10_at",    dos_at, 17);

    run_seq(60, 0, 20, -1);
    check("dp20_ndos", n_dos, 1);
    check("dp20_at",   dos_at, 27);

    run_seq(61, 0, 21, -1);
    check("dp21_npuls", n_puls, 2);
    check("dp21_ndos",  n_dos, 0);

    run_seq(60, 0, 8, 16);
    check("tri_npuls", n_puls, 3);
    check("tri_ndos",  n_dos, 1);
    check("tri_at",    dos_at, 15);

    // Round timer: start sampled at index 1, extra starts ignored.
    do_reset();
    first_fin = -1;
    for (int c = 0; c < 220; c++) begin
      start = (c == 0) || (c == 50) || (c == 150);
      step();
      if (finalizar && first_fin < 0) first_fin = c + 1;
      if (c + 1 == 1)   check("tmr_cnt_1",   32'(cuenta_ronda), 0);
      if (c + 1 == 51)  check("tmr_cnt_51",  32'(cuenta_ronda), 50);
      if (c + 1 == 100) check("tmr_fin_100", 32'(finalizar), 0);
      if (c + 1 == 100) check("tmr_cnt_100", 32'(cuenta_ronda), 99);
      if (c + 1 == 101) check("tmr_cnt_101", 32'(cuenta_ronda), 99);
    end
    start = 1'b0;
    check("tmr_first_fin", first_fin, 101);
    check("tmr_fin_hold",  32'(finalizar), 1);
    check("tmr_cnt_hold",  32'(cuenta_ronda), 99);

    run_seq(50, 0, 10, -1);
    check("done_dos_ndos", n_dos, 1);
    check("done_dos_at",   dos_at, 17);
    check("done_fin",      32'(finalizar), 1);

    // Reset mid-round with DP_WAIT active (second press pulse at index 36).
    do_reset();
    for (int c = 0; c < 40; c++) begin
      start   = (c == 0);
      btn_raw = in_press(c, 0) || in_press(c, 30);
      step();
    end
    start = 1'b0; btn_raw = 1'b0;
    check("mid_cnt_40", 32'(cuenta_ronda), 39);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_cnt", 32'(cuenta_ronda), 0);
    check("mid_rst_fin", 32'(finalizar), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    run_seq(100, 0, -1, -1);
    check("mid_npuls", n_puls, 1);
    check("mid_ndos",  n_dos, 0);
    check("mid_fin",   32'(finalizar), 0);
    check("mid_cnt",   32'(cuenta_ronda), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
